// File: rtl/demux_one_to_five_if.sv
// ============================================================================
// Module      : demux_one_to_five_if
// Description : Bundle of routing, handshake and result signals for the
//               1-to-5 result demultiplexer.
//               master : producer/consumer side (drives op, entrada,
//                        entrada_valida, consumir).
//               slave  : demultiplexer side (drives pronto, a..e, validos,
//                        contagem, sobrescrita).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_one_to_five_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       op;
  logic [WIDTH-1:0] entrada;
  logic             entrada_valida;
  logic             pronto;
  logic [4:0]       consumir;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [4:0]       validos;
  logic [7:0]       contagem;
  logic             sobrescrita;

  modport master (
    output op, entrada, entrada_valida, consumir,
    input  pronto, a, b, c, d, e, validos, contagem, sobrescrita
  );

  modport slave (
    input  op, entrada, entrada_valida, consumir,
    output pronto, a, b, c, d, e, validos, contagem, sobrescrita
  );
endinterface

`default_nettype wire

// File: rtl/demux_one_to_five.sv
// ============================================================================
// Module      : demux_one_to_five
// Description : Registered 1-to-5 demultiplexer with per-destination
//               valid/consume handshake. Routes one WIDTH-bit word into one
//               of five holding registers selected by op
//               (000 a, 001 b, 010 c, 011 d, 1xx e).
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - demux_one_to_five_if.slave (op, entrada,
//                        entrada_valida, consumir in; pronto, a..e,
//                        validos, contagem, sobrescrita out)
// Config      : DEMUX_OVERWRITE_EN - when defined, pronto is constant 1 and
//               accepting into a full destination overwrites it and sets
//               the sticky sobrescrita flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_one_to_five #(
  parameter int WIDTH = 16
) (
  input  wire logic          clock,
  input  wire logic          reset,
  demux_one_to_five_if.slave bus
);

  logic [WIDTH-1:0] data_q [5];
  logic [WIDTH-1:0] data_d [5];
  logic [4:0]       validos_q;
  logic [4:0]       validos_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;

  logic [2:0]       dest;
  logic             pronto;
  logic             accept;

  always_comb begin
    // op[2] set aliases every remaining code onto e.
    dest = bus.op[2] ? 3'd4 : {1'b0, bus.op[1:0]};
`ifdef DEMUX_OVERWRITE_EN
    pronto = 1'b1;
`else
    // A slot freed by a consume this same edge can be refilled: bubble-free.
    pronto = ~validos_q[dest] | bus.consumir[dest];
`endif
    accept = bus.entrada_valida & pronto;

    data_d    = data_q;
    validos_d = validos_q & ~bus.consumir;
    cnt_d     = cnt_q;
    if (accept) begin
      data_d[dest]    = bus.entrada;
      validos_d[dest] = 1'b1;
      cnt_d           = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q    <= '{default: '0};
      validos_q <= '0;
      cnt_q     <= '0;
    end else begin
      data_q    <= data_d;
      validos_q <= validos_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef DEMUX_OVERWRITE_EN
  logic sob_q;
  logic sob_d;

  always_comb begin
    sob_d = sob_q;
    if (accept && validos_q[dest] && !bus.consumir[dest]) begin
      sob_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sob_q <= 1'b0;
    end else begin
      sob_q <= sob_d;
    end
  end

  assign bus.sobrescrita = sob_q;
`else
  assign bus.sobrescrita = 1'b0;
`endif

  assign bus.pronto   = pronto;
  assign bus.a        = data_q[0];
  assign bus.b        = data_q[1];
  assign bus.c        = data_q[2];
  assign bus.d        = data_q[3];
  assign bus.e        = data_q[4];
  assign bus.validos  = validos_q;
  assign bus.contagem = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_one_to_five.sv
// ============================================================================
// Module      : tb_demux_one_to_five
// Description : Self-checking bench for demux_one_to_five. A behavioural
//               model of the five mailboxes is compared against the DUT on
//               every falling edge; directed literal checks pin key points.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_one_to_five;

  logic clock;
  logic reset;

  demux_one_to_five_if #(.WIDTH(16)) bus ();

  demux_one_to_five #(.WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: five mailboxes + counter ----------
  logic [15:0] m_data [5];
  bit          m_full [5];
  int          m_cnt;
  bit          m_sob;
  bit          chk_en = 1'b0;

  function automatic int dest_of(input logic [2:0] op);
    return (op >= 3'd4) ? 4 : int'(op);
  endfunction

  function automatic bit can_take(input int dst);
`ifdef DEMUX_OVERWRITE_EN
    return 1'b1;
`else
    return !m_full[dst] || bus.consumir[dst];
`endif
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        m_data[i] = 16'h0;
        m_full[i] = 1'b0;
      end
      m_cnt  = 0;
      m_sob  = 1'b0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      int  dst;
      bit  take;
      bit  was_full;
      dst      = dest_of(bus.op);
      take     = bus.entrada_valida && can_take(dst);
      was_full = m_full[dst] && !bus.consumir[dst];
      for (int i = 0; i < 5; i++)
        if (bus.consumir[i]) m_full[i] = 1'b0;
      if (take) begin
        m_data[dst] = bus.entrada;
        m_full[dst] = 1'b1;
        m_cnt       = (m_cnt + 1) % 256;
        if (was_full) m_sob = 1'b1;
      end
    end
  end

  // ---------------- single compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      logic [4:0] ev;
      for (int i = 0; i < 5; i++) ev[i] = m_full[i];
      chk("pronto",   {31'b0, bus.pronto},   {31'b0, can_take(dest_of(bus.op))});
      chk("a",        {16'b0, bus.a},        {16'b0, m_data[0]});
      chk("b",        {16'b0, bus.b},        {16'b0, m_data[1]});
      chk("c",        {16'b0, bus.c},        {16'b0, m_data[2]});
      chk("d",        {16'b0, bus.d},        {16'b0, m_data[3]});
      chk("e",        {16'b0, bus.e},        {16'b0, m_data[4]});
      chk("validos",  {27'b0, bus.validos},  {27'b0, ev});
      chk("contagem", {24'b0, bus.contagem}, m_cnt);
      chk("sobrescrita", {31'b0, bus.sobrescrita}, {31'b0, m_sob});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ev, input logic [2:0] op,
                       input logic [15:0] dat, input logic [4:0] cons);
    bus.entrada_valida = ev;
    bus.op             = op;
    bus.entrada        = dat;
    bus.consumir       = cons;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 5'b0);
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 5'b0);

    // Reset then route to a
    do_reset(2);
    chk("rst_a",        {16'b0, bus.a}, 32'h0);
    chk("rst_e",        {16'b0, bus.e}, 32'h0);
    chk("rst_validos",  {27'b0, bus.validos}, 32'h0);
    chk("rst_contagem", {24'b0, bus.contagem}, 32'h0);
    chk("rst_sob",      {31'b0, bus.sobrescrita}, 32'h0);
    drive(1'b1, 3'b000, 16'h1234, 5'b0);
    tick();
    chk("route_a",       {16'b0, bus.a}, 32'h1234);
    chk("route_validos", {27'b0, bus.validos}, 32'h01);
    chk("route_cnt",     {24'b0, bus.contagem}, 32'h1);

    // Op map including aliases
    do_reset(1);
    drive(1'b1, 3'b001, 16'h0B0B, 5'b0); tick();
    drive(1'b1, 3'b010, 16'h0C0C, 5'b0); tick();
    drive(1'b1, 3'b011, 16'h0D0D, 5'b0); tick();
    drive(1'b1, 3'b101, 16'h0E01, 5'b0); tick();
    drive(1'b1, 3'b111, 16'h0E02, 5'b0);
`ifndef DEMUX_OVERWRITE_EN
    chk("alias_pronto_full_e", {31'b0, bus.pronto}, 32'h0);
`endif
    tick();
    chk("map_b", {16'b0, bus.b}, 32'h0B0B);
    chk("map_c", {16'b0, bus.c}, 32'h0C0C);
    chk("map_d", {16'b0, bus.d}, 32'h0D0D);
`ifdef DEMUX_OVERWRITE_EN
    chk("map_e", {16'b0, bus.e}, 32'h0E02);
    chk("map_cnt", {24'b0, bus.contagem}, 32'h5);
`else
    // Second write to e is back-pressured since e is still full.
    chk("map_e", {16'b0, bus.e}, 32'h0E01);
    chk("map_cnt", {24'b0, bus.contagem}, 32'h4);
`endif
    chk("map_validos", {27'b0, bus.validos}, 32'h1E);

    // Backpressure on c, then release with same-cycle consume
    drive(1'b1, 3'b010, 16'hC0FF, 5'b0);
    #2;
`ifndef DEMUX_OVERWRITE_EN
    chk("bp_pronto0", {31'b0, bus.pronto}, 32'h0);
    tick();
    chk("bp_c_hold", {16'b0, bus.c}, 32'h0C0C);
    chk("bp_cnt_hold", {24'b0, bus.contagem}, 32'h4);
`else
    tick();
    chk("bp_c_ovw", {16'b0, bus.c}, 32'hC0FF);
`endif
    drive(1'b1, 3'b010, 16'hC1FF, 5'b00100);
    #2;
    chk("bp_pronto1", {31'b0, bus.pronto}, 32'h1);
    tick();
    chk("bp_c_new", {16'b0, bus.c}, 32'hC1FF);
    chk("bp_validos2", {31'b0, bus.validos[2]}, 32'h1);

    // Consume only
    drive(1'b1, 3'b000, 16'h00A1, 5'b0); tick();
    chk("full_validos", {27'b0, bus.validos}, 32'h1F);
    drive(1'b0, 3'b000, 16'hFFFF, 5'b10001); tick();
    drive(1'b0, 3'b000, 16'h0, 5'b0);
    chk("cons_validos", {27'b0, bus.validos}, 32'h0E);
    chk("cons_a_hold", {16'b0, bus.a}, 32'h00A1);
    chk("cons_c_hold", {16'b0, bus.c}, 32'hC1FF);
    tick();

    // Wrap the counter with 256 bubble-free accepts
    do_reset(1);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3'(i % 5), 16'(i * 16'h0101), 5'(1 << (i % 5)));
      tick();
    end
    chk("wrap_cnt", {24'b0, bus.contagem}, 32'h0);
    // Reset wins over a same-cycle accept to d
    reset = 1'b1;
    drive(1'b1, 3'b011, 16'hDDDD, 5'b0);
    tick();
    reset = 1'b0;
    drive(1'b0, 3'b000, 16'h0, 5'b0);
    chk("rstmid_d", {16'b0, bus.d}, 32'h0);
    chk("rstmid_validos", {27'b0, bus.validos}, 32'h0);
    chk("rstmid_cnt", {24'b0, bus.contagem}, 32'h0);

    // Overwrite behaviour on e
    drive(1'b1, 3'b100, 16'hAAAA, 5'b0); tick();
    drive(1'b1, 3'b100, 16'h5555, 5'b0);
    #2;
`ifdef DEMUX_OVERWRITE_EN
    chk("ovw_pronto", {31'b0, bus.pronto}, 32'h1);
    tick();
    chk("ovw_e", {16'b0, bus.e}, 32'h5555);
    chk("ovw_sob", {31'b0, bus.sobrescrita}, 32'h1);
    chk("ovw_cnt", {24'b0, bus.contagem}, 32'h2);
`else
    chk("ovw_pronto", {31'b0, bus.pronto}, 32'h0);
    tick();
    chk("ovw_e", {16'b0, bus.e}, 32'hAAAA);
    chk("ovw_sob", {31'b0, bus.sobrescrita}, 32'h0);
    chk("ovw_cnt", {24'b0, bus.contagem}, 32'h1);
`endif
    drive(1'b0, 3'b000, 16'h0, 5'b0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
